// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
// Module      : load_store_queue
// Description : In-order load/store queue between the rv32i execute stage and
//               the data-memory request/grant/response bus. Buffers up to
//               C_DEPTH memory operations, issues them one at a time, aligns
//               and sign/zero-extends load data and writes it back to the
//               register file.
// Ports       : clk_i/reset_i/clk_en_i   clock, async active-high reset, enable
//               ex_*                     push interface from execute stage
//               ex_full_o                registered "stop issuing" flag
//               empty_o                  queue empty and bus idle (fences)
//               dmem_*                   request/grant/response memory bus
//               wb_*                     register-file write-back (1-cycle strobe)
//               exc_misalign_o/exc_addr_o  only with LSQ_MISALIGN_TRAP_EN
// Options     : `define LSQ_MISALIGN_TRAP_EN to trap misaligned half/word
//               accesses instead of accessing the containing aligned unit.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_queue #(
    parameter int C_XLEN  = 32,
    parameter int C_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clk_en_i,
    input  logic                  ex_lq_wr_i,
    input  logic                  ex_sq_wr_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [4:0]            ex_regd_addr_i,
    input  logic [C_XLEN-1:0]     ex_regs2_data_i,
    input  logic [C_XLEN-1:0]     ex_addr_i,
    output logic                  ex_full_o,
    output logic                  empty_o,
    output logic                  dmem_req_o,
    input  logic                  dmem_gnt_i,
    output logic                  dmem_we_o,
    output logic [C_XLEN/8-1:0]   dmem_be_o,
    output logic [C_XLEN-1:0]     dmem_addr_o,
    output logic [C_XLEN-1:0]     dmem_wdata_o,
    input  logic                  dmem_rvalid_i,
    input  logic [C_XLEN-1:0]     dmem_rdata_i,
`ifdef LSQ_MISALIGN_TRAP_EN
    output logic                  exc_misalign_o,
    output logic [C_XLEN-1:0]     exc_addr_o,
`endif
    output logic                  wb_regd_wr_o,
    output logic [4:0]            wb_regd_addr_o,
    output logic [C_XLEN-1:0]     wb_regd_data_o
);

    localparam int c_ptr_w = $clog2(C_DEPTH);
    localparam int c_cnt_w = $clog2(C_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(C_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(C_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Queue storage (not reset: contents are only observed through valid entries)
    logic                r_q_store [C_DEPTH];
    logic [2:0]          r_q_f3    [C_DEPTH];
    logic [4:0]          r_q_rd    [C_DEPTH];
    logic [C_XLEN-1:0]   r_q_addr  [C_DEPTH];
    logic [C_XLEN-1:0]   r_q_data  [C_DEPTH];

    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  w_count_nxt;
    logic                r_full;
    state_t              r_state;
    state_t              w_state_nxt;

    logic                w_push;
    logic                w_pop;
    logic                w_trap;
    logic                w_more;

    logic                r_wb_wr;
    logic [4:0]          r_wb_addr;
    logic [C_XLEN-1:0]   r_wb_data;

    // Head-of-queue view
    logic                w_head_store;
    logic [2:0]          w_head_f3;
    logic [4:0]          w_head_rd;
    logic [C_XLEN-1:0]   w_head_addr;
    logic [C_XLEN-1:0]   w_head_data;

    logic                w_is_byte;
    logic                w_is_half;
    logic                w_unsigned;
    logic                w_misalign;
    logic [1:0]          w_lane;
    logic [3:0]          w_be;
    logic [C_XLEN-1:0]   w_wdata;
    logic [C_XLEN-1:0]   w_rshift;
    logic [C_XLEN-1:0]   w_load_data;

    assign w_head_store = r_q_store[r_rd_ptr];
    assign w_head_f3    = r_q_f3[r_rd_ptr];
    assign w_head_rd    = r_q_rd[r_rd_ptr];
    assign w_head_addr  = r_q_addr[r_rd_ptr];
    assign w_head_data  = r_q_data[r_rd_ptr];

    // Size decode; reserved funct3 codes fall through to word
    assign w_is_byte  = (w_head_f3 == 3'b000) || (w_head_f3 == 3'b100);
    assign w_is_half  = (w_head_f3 == 3'b001) || (w_head_f3 == 3'b101);
    assign w_unsigned = w_head_f3[2];

`ifdef LSQ_MISALIGN_TRAP_EN
    assign w_misalign = (w_is_half && w_head_addr[0]) ||
                        (!w_is_byte && !w_is_half && (w_head_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Byte lane of the access within the word; half/word snap to their
    // containing aligned unit so be, wdata and load shift stay consistent.
    always_comb begin
        w_lane = 2'b00;
        if (w_is_byte) begin
            w_lane = w_head_addr[1:0];
        end else if (w_is_half) begin
            w_lane = {w_head_addr[1], 1'b0};
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = w_head_data;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{w_head_data[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << w_lane;
            w_wdata = {2{w_head_data[15:0]}};
        end
    end

    assign w_rshift = dmem_rdata_i >> {w_lane, 3'b000};

    always_comb begin
        w_load_data = w_rshift;
        if (w_is_byte) begin
            w_load_data = {{(C_XLEN-8){w_rshift[7] & ~w_unsigned}}, w_rshift[7:0]};
        end else if (w_is_half) begin
            w_load_data = {{(C_XLEN-16){w_rshift[15] & ~w_unsigned}}, w_rshift[15:0]};
        end
    end

    // Queue bookkeeping
    assign w_push = (ex_lq_wr_i || ex_sq_wr_i) && (r_count != c_cnt_max);
    assign w_more = (r_count > c_cnt_one);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    // FSM next-state; a popping op moves straight on to the next entry
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_trap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    if (w_misalign) begin
                        w_pop  = 1'b1;
                        w_trap = 1'b1;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    if (w_head_store) begin
                        w_pop       = 1'b1;
                        w_state_nxt = w_more ? ST_REQ : ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (dmem_rvalid_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_more ? ST_REQ : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clk_en_i && w_push) begin
            r_q_store[r_wr_ptr] <= ex_sq_wr_i;
            r_q_f3[r_wr_ptr]    <= ex_funct3_i;
            r_q_rd[r_wr_ptr]    <= ex_regd_addr_i;
            r_q_addr[r_wr_ptr]  <= ex_addr_i;
            r_q_data[r_wr_ptr]  <= ex_regs2_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_wb_wr   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (clk_en_i) begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            // One slot of slack absorbs the push already in flight upstream
            r_full  <= (w_count_nxt >= c_cnt_full);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_wb_wr <= 1'b0;
            if ((r_state == ST_RSP) && dmem_rvalid_i) begin
                r_wb_wr   <= (w_head_rd != 5'd0);
                r_wb_addr <= w_head_rd;
                r_wb_data <= w_load_data;
            end
        end
    end

`ifdef LSQ_MISALIGN_TRAP_EN
    logic              r_exc;
    logic [C_XLEN-1:0] r_exc_addr;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_exc      <= 1'b0;
            r_exc_addr <= '0;
        end else if (clk_en_i) begin
            r_exc <= w_trap;
            if (w_trap) begin
                r_exc_addr <= w_head_addr;
            end
        end
    end

    assign exc_misalign_o = r_exc;
    assign exc_addr_o     = r_exc_addr;
`else
    logic w_trap_unused;
    assign w_trap_unused = w_trap;
`endif

    // Bus outputs decode the state register so reset removes the request at once
    assign dmem_req_o   = (r_state == ST_REQ);
    assign dmem_we_o    = dmem_req_o && w_head_store;
    assign dmem_be_o    = dmem_req_o ? w_be : '0;
    assign dmem_addr_o  = dmem_req_o ? {w_head_addr[C_XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata_o = (dmem_req_o && w_head_store) ? w_wdata : '0;

    assign ex_full_o      = r_full;
    assign empty_o        = (r_count == '0) && (r_state == ST_IDLE);
    assign wb_regd_wr_o   = r_wb_wr;
    assign wb_regd_addr_o = r_wb_addr;
    assign wb_regd_data_o = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_load_store_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_queue
// Description : Directed self-checking bench for load_store_queue. Stores,
//               loads (sign/zero/rd0), back-pressure ordering, clock enable,
//               misaligned word load and asynchronous reset mid-request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_queue;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic        ex_lq_wr_i;
    logic        ex_sq_wr_i;
    logic [2:0]  ex_funct3_i;
    logic [4:0]  ex_regd_addr_i;
    logic [31:0] ex_regs2_data_i;
    logic [31:0] ex_addr_i;
    logic        ex_full_o;
    logic        empty_o;
    logic        dmem_req_o;
    logic        dmem_gnt_i;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_regd_wr_o;
    logic [4:0]  wb_regd_addr_o;
    logic [31:0] wb_regd_data_o;
`ifdef LSQ_MISALIGN_TRAP_EN
    logic        exc_misalign_o;
    logic [31:0] exc_addr_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    load_store_queue #(.C_XLEN(32), .C_DEPTH(4)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .clk_en_i        (clk_en_i),
        .ex_lq_wr_i      (ex_lq_wr_i),
        .ex_sq_wr_i      (ex_sq_wr_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_regd_addr_i  (ex_regd_addr_i),
        .ex_regs2_data_i (ex_regs2_data_i),
        .ex_addr_i       (ex_addr_i),
        .ex_full_o       (ex_full_o),
        .empty_o         (empty_o),
        .dmem_req_o      (dmem_req_o),
        .dmem_gnt_i      (dmem_gnt_i),
        .dmem_we_o       (dmem_we_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
`ifdef LSQ_MISALIGN_TRAP_EN
        .exc_misalign_o  (exc_misalign_o),
        .exc_addr_o      (exc_addr_o),
`endif
        .wb_regd_wr_o    (wb_regd_wr_o),
        .wb_regd_addr_o  (wb_regd_addr_o),
        .wb_regd_data_o  (wb_regd_data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_i) begin
            assert (!(ex_lq_wr_i && ex_sq_wr_i))
                else $error("both push strobes high together");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] d);
        ex_sq_wr_i      = st;
        ex_lq_wr_i      = ~st;
        ex_funct3_i     = f3;
        ex_regd_addr_i  = rd;
        ex_addr_i       = a;
        ex_regs2_data_i = d;
        tick();
        ex_sq_wr_i = 1'b0;
        ex_lq_wr_i = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!dmem_req_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, {31'd0, dmem_req_o}, 32'd1);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] exp_be,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        push(1'b1, f3, 5'd0, a, d);
        wait_req(tag);
        check({tag, "_we"},    {31'd0, dmem_we_o}, 32'd1);
        check({tag, "_be"},    {28'd0, dmem_be_o}, {28'd0, exp_be});
        check({tag, "_addr"},  dmem_addr_o, exp_addr);
        check({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        check({tag, "_req_done"}, {31'd0, dmem_req_o}, 32'd0);
        check({tag, "_empty"},    {31'd0, empty_o}, 32'd1);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_addr,
                           input logic exp_wr, input logic [31:0] exp_data);
        push(1'b0, f3, rd, a, 32'd0);
        wait_req(tag);
        check({tag, "_we"},   {31'd0, dmem_we_o}, 32'd0);
        check({tag, "_be"},   {28'd0, dmem_be_o}, {28'd0, exp_be});
        check({tag, "_addr"}, dmem_addr_o, exp_addr);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        check({tag, "_req_rsp"}, {31'd0, dmem_req_o}, 32'd0);
        check({tag, "_wb_early"}, {31'd0, wb_regd_wr_o}, 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        tick();
        dmem_rvalid_i = 1'b0;
        check({tag, "_wb_wr"}, {31'd0, wb_regd_wr_o}, {31'd0, exp_wr});
        if (exp_wr) begin
            check({tag, "_wb_addr"}, {27'd0, wb_regd_addr_o}, {27'd0, rd});
            check({tag, "_wb_data"}, wb_regd_data_o, exp_data);
        end
        tick();
        check({tag, "_wb_pulse"}, {31'd0, wb_regd_wr_o}, 32'd0);
        check({tag, "_empty"},    {31'd0, empty_o}, 32'd1);
    endtask

    initial begin
        reset_i = 1'b1;  clk_en_i = 1'b1;
        ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0; ex_funct3_i = 3'b000;
        ex_regd_addr_i = 5'd0; ex_regs2_data_i = 32'd0; ex_addr_i = 32'd0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
        tick(); tick();
        check("rst_empty", {31'd0, empty_o}, 32'd1);
        check("rst_req",   {31'd0, dmem_req_o}, 32'd0);
        reset_i = 1'b0;
        tick();
        check("init_full", {31'd0, ex_full_o}, 32'd0);
        check("init_wb",   {31'd0, wb_regd_wr_o}, 32'd0);

        // Stores: word and replicated byte
        do_store("sw", 3'b010, 32'h104, 32'hDEADBEEF, 4'b1111, 32'h104, 32'hDEADBEEF);
        do_store("sb", 3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'h100, 32'hA5A5A5A5);
        do_store("sh", 3'b001, 32'h106, 32'h0000BEEF, 4'b1100, 32'h104, 32'hBEEFBEEF);

        // Loads: sign, zero, rd0, half
        do_load("lb",  3'b000, 5'd5, 32'h102, 32'h00800000, 4'b0100, 32'h100, 1'b1, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 5'd5, 32'h102, 32'h00800000, 4'b0100, 32'h100, 1'b1, 32'h00000080);
        do_load("lb0", 3'b000, 5'd0, 32'h102, 32'h00800000, 4'b0100, 32'h100, 1'b0, 32'h0);
        do_load("lh",  3'b001, 5'd9, 32'h202, 32'h8001ABCD, 4'b1100, 32'h200, 1'b1, 32'hFFFF8001);

        // Clock enable low: push is ignored
        clk_en_i = 1'b0;
        push(1'b1, 3'b010, 5'd0, 32'h300, 32'h1);
        tick();
        check("cen_empty", {31'd0, empty_o}, 32'd1);
        check("cen_req",   {31'd0, dmem_req_o}, 32'd0);
        clk_en_i = 1'b1;

        // Back-pressure: three pushes with no grant, then push+grant, then drain
        push(1'b1, 3'b010, 5'd0, 32'h10, 32'h11111111);
        check("bp_full1", {31'd0, ex_full_o}, 32'd0);
        push(1'b1, 3'b010, 5'd0, 32'h20, 32'h22222222);
        check("bp_full2", {31'd0, ex_full_o}, 32'd0);
        check("bp_head1", dmem_addr_o, 32'h10);
        push(1'b1, 3'b010, 5'd0, 32'h30, 32'h33333333);
        check("bp_full3", {31'd0, ex_full_o}, 32'd1);
        check("bp_hold",  dmem_addr_o, 32'h10);
        dmem_gnt_i = 1'b1;
        push(1'b1, 3'b010, 5'd0, 32'h40, 32'h44444444);
        check("bp_full_pp", {31'd0, ex_full_o}, 32'd1);
        check("bp_head2",   dmem_addr_o, 32'h20);
        tick();
        check("bp_full_dr", {31'd0, ex_full_o}, 32'd0);
        check("bp_head3",   dmem_addr_o, 32'h30);
        tick();
        check("bp_head4",   dmem_addr_o, 32'h40);
        check("bp_wdata4",  dmem_wdata_o, 32'h44444444);
        tick();
        dmem_gnt_i = 1'b0;
        check("bp_req_end", {31'd0, dmem_req_o}, 32'd0);
        check("bp_empty",   {31'd0, empty_o}, 32'd1);

        // Misaligned word load
`ifdef LSQ_MISALIGN_TRAP_EN
        push(1'b0, 3'b010, 5'd7, 32'h101, 32'd0);
        tick();
        check("mis_exc",      {31'd0, exc_misalign_o}, 32'd1);
        check("mis_exc_addr", exc_addr_o, 32'h101);
        check("mis_req",      {31'd0, dmem_req_o}, 32'd0);
        tick();
        check("mis_exc_pulse", {31'd0, exc_misalign_o}, 32'd0);
        check("mis_req2",      {31'd0, dmem_req_o}, 32'd0);
        check("mis_wb",        {31'd0, wb_regd_wr_o}, 32'd0);
        check("mis_empty",     {31'd0, empty_o}, 32'd1);
`else
        do_load("lw_mis", 3'b010, 5'd7, 32'h101, 32'h12345678, 4'b1111, 32'h100, 1'b1, 32'h12345678);
`endif

        // Asynchronous reset in the middle of a request
        push(1'b1, 3'b010, 5'd0, 32'h500, 32'h55555555);
        wait_req("rst_mid");
        #3;
        reset_i = 1'b1;
        #1;
        check("rst_async_req", {31'd0, dmem_req_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        tick();
        check("rst_rel_empty", {31'd0, empty_o}, 32'd1);
        check("rst_rel_full",  {31'd0, ex_full_o}, 32'd0);
        check("rst_rel_wb",    {31'd0, wb_regd_wr_o}, 32'd0);
        check("rst_rel_req",   {31'd0, dmem_req_o}, 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFFFFFF;
        tick();
        dmem_rvalid_i = 1'b0;
        check("stale_rvalid_wb",    {31'd0, wb_regd_wr_o}, 32'd0);
        check("stale_rvalid_empty", {31'd0, empty_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
